// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage access sequencer with timeout, writeback backpressure and access counter
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  input  logic [2:0]  REQ_CTRL,
  input  logic [47:0] REQ_ADDRESS,
  input  logic        WB_READY,
  output logic        STALL,
  output logic        RSP_VALID,
  output logic [47:0] RSP_DATA,
  output logic        RSP_ERROR,
  output logic        MA_ENABLE,
  output logic [2:0]  MA_CTRL,
  output logic [47:0] MA_ADDRESS,
  input  logic [47:0] MA_READ,
  input  logic        MA_HANDSHAKE,
  output logic [15:0] REQ_COUNT
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] to_cnt;

  // Decoded from the state register so reset drops them without waiting for an edge.
  assign MA_ENABLE = (state == ST_WAIT);
  assign RSP_VALID = (state == ST_RESP);
  assign STALL     = REQ_VALID && !((state == ST_RESP) && WB_READY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      MA_CTRL    <= '0;
      MA_ADDRESS <= '0;
      RSP_DATA   <= '0;
      RSP_ERROR  <= 1'b0;
      REQ_COUNT  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            MA_CTRL    <= REQ_CTRL;
            MA_ADDRESS <= REQ_ADDRESS;
            to_cnt     <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A handshake on the final timeout cycle still completes normally.
          if (MA_HANDSHAKE) begin
            RSP_DATA  <= MA_READ;
            RSP_ERROR <= 1'b0;
            state     <= ST_RESP;
          end else if (to_cnt == TO_LAST) begin
            RSP_DATA  <= '0;
            RSP_ERROR <= 1'b1;
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (WB_READY) begin
            if (REQ_COUNT != 16'hFFFF) begin
              REQ_COUNT <= REQ_COUNT + 16'd1;
            end
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl: vector table, random transactions, reset corner cases
module tb_mem_stage_ctrl;

  localparam int T = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic [2:0]  REQ_CTRL;
  logic [47:0] REQ_ADDRESS;
  logic        WB_READY;
  logic        STALL;
  logic        RSP_VALID;
  logic [47:0] RSP_DATA;
  logic        RSP_ERROR;
  logic        MA_ENABLE;
  logic [2:0]  MA_CTRL;
  logic [47:0] MA_ADDRESS;
  logic [47:0] MA_READ;
  logic        MA_HANDSHAKE;
  logic [15:0] REQ_COUNT;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_CTRL(REQ_CTRL),
    .REQ_ADDRESS(REQ_ADDRESS), .WB_READY(WB_READY), .STALL(STALL),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERROR(RSP_ERROR),
    .MA_ENABLE(MA_ENABLE), .MA_CTRL(MA_CTRL), .MA_ADDRESS(MA_ADDRESS),
    .MA_READ(MA_READ), .MA_HANDSHAKE(MA_HANDSHAKE), .REQ_COUNT(REQ_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  ctrl;
    logic [47:0] addr;
    logic [47:0] rd;
    int          d;         // WAIT cycle (1-based) carrying the handshake; 0 = never
    int          bp;        // RESP cycles with WB_READY low
    int          exp_wait;
    logic        exp_err;
    logic [47:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  int nvec = 0;
  int nerr = 0;
  logic [15:0] model_count = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [2:0] ctrl, input logic [47:0] addr, input logic [47:0] rd,
                         input int d, input int bp, input int exp_wait, input logic exp_err,
                         input logic [47:0] exp_data, input bit rnd);
    int wait_cnt;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_CTRL = ctrl; REQ_ADDRESS = addr;
    MA_HANDSHAKE = 1'b0; WB_READY = 1'b0; MA_READ = rd;
    #1;
    chk("idle_ma_enable", 64'(MA_ENABLE), 64'd0);
    chk("idle_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("idle_stall", 64'(STALL), 64'd1);
    wait_cnt = 0;
    for (int i = 1; i <= T + 4; i++) begin
      @(negedge CLK);
      MA_HANDSHAKE = (i == d);
      if (rnd) begin
        REQ_VALID   = 1'($urandom_range(0, 1));
        REQ_CTRL    = 3'($urandom);
        REQ_ADDRESS = 48'({$urandom(), $urandom()});
      end
      #1;
      if (!MA_ENABLE) break;
      wait_cnt++;
      chk("wait_ma_ctrl", 64'(MA_CTRL), 64'(ctrl));
      chk("wait_ma_address", 64'(MA_ADDRESS), 64'(addr));
    end
    MA_HANDSHAKE = 1'b0;
    chk("wait_cycles", 64'(wait_cnt), 64'(exp_wait));
    for (int j = 0; j <= bp; j++) begin
      REQ_VALID = 1'b1;
      WB_READY  = (j == bp);
      #1;
      chk("resp_valid", 64'(RSP_VALID), 64'd1);
      chk("resp_data", 64'(RSP_DATA), 64'(exp_data));
      chk("resp_error", 64'(RSP_ERROR), 64'(exp_err));
      chk("resp_stall", 64'(STALL), (j != bp) ? 64'd1 : 64'd0);
      if (j < bp) @(negedge CLK);
    end
    @(negedge CLK);
    WB_READY = 1'b0;
    if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
    #1;
    chk("release_ma_enable", 64'(MA_ENABLE), 64'd0);
    chk("release_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("release_req_count", 64'(REQ_COUNT), 64'(model_count));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ma_enable"}, 64'(MA_ENABLE), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd0);
    chk({tag, "_rsp_data"}, 64'(RSP_DATA), 64'd0);
    chk({tag, "_rsp_error"}, 64'(RSP_ERROR), 64'd0);
    chk({tag, "_ma_ctrl"}, 64'(MA_CTRL), 64'd0);
    chk({tag, "_ma_address"}, 64'(MA_ADDRESS), 64'd0);
    chk({tag, "_req_count"}, 64'(REQ_COUNT), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b000, 48'h10, 48'hABCD, 5, 0, 5, 1'b0, 48'hABCD};
    vecs[1] = '{3'b000, 48'h20, 48'h1234, 0, 0, 8, 1'b1, 48'h0};
    vecs[2] = '{3'b010, 48'h30, 48'h5555, 2, 4, 2, 1'b0, 48'h5555};
    vecs[3] = '{3'b000, 48'h40, 48'h1111, 1, 0, 1, 1'b0, 48'h1111};
    vecs[4] = '{3'b001, 48'h50, 48'h2222, 3, 0, 3, 1'b0, 48'h2222};
    vecs[5] = '{3'b110, 48'h60, 48'h3333, 8, 1, 8, 1'b0, 48'h3333};
    vecs[6] = '{3'b101, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 9, 0, 8, 1'b1, 48'h0};

    RESET = 1'b1; REQ_VALID = 1'b0; REQ_CTRL = '0; REQ_ADDRESS = '0;
    WB_READY = 1'b0; MA_READ = '0; MA_HANDSHAKE = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_reset_values("por");
    chk("por_stall", 64'(STALL), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_txn(vecs[k].ctrl, vecs[k].addr, vecs[k].rd, vecs[k].d, vecs[k].bp,
              vecs[k].exp_wait, vecs[k].exp_err, vecs[k].exp_data, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      logic [47:0] rd;
      int d;
      int ew;
      logic ee;
      logic [47:0] ed;
      rd = 48'({$urandom(), $urandom()});
      d  = int'($urandom_range(0, T + 2));
      // Handshake inside the WAIT window completes; otherwise the access times out after T cycles.
      if (d >= 1 && d <= T) begin
        ew = d; ee = 1'b0; ed = rd;
      end else begin
        ew = T; ee = 1'b1; ed = 48'h0;
      end
      run_txn(3'($urandom), 48'({$urandom(), $urandom()}), rd, d, int'($urandom_range(0, 3)),
              ew, ee, ed, 1'b1);
    end

    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_CTRL = 3'b101; REQ_ADDRESS = 48'h77;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    #1;
    chk("rst_pre_ma_enable", 64'(MA_ENABLE), 64'd1);
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_values("rst_mid_wait");
    model_count = 16'd0;
    @(negedge CLK);
    RESET = 1'b0; MA_HANDSHAKE = 1'b1; MA_READ = 48'hDEAD;
    @(negedge CLK);
    MA_HANDSHAKE = 1'b0;
    #1;
    chk("rst_late_hs_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("rst_late_hs_ma_enable", 64'(MA_ENABLE), 64'd0);
    @(negedge CLK);
    #1;
    chk("rst_late_hs_rsp_valid2", 64'(RSP_VALID), 64'd0);

    run_txn(3'b011, 48'h1234_5678, 48'hBEEF, 4, 2, 4, 1'b0, 48'hBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max cycles in WAIT before abort.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port REQ_VALID  input  1  memory-stage instruction needs a memory access.
REQ-005 SHALL have port REQ_CTRL  input  3  access control; bit0 selects kernel (0) or picture (1) memory; bits[2:1] select operation.
REQ-006 SHALL have port REQ_ADDRESS  input  48  access address.
REQ-007 SHALL have port WB_READY  input  1  writeback stage accepts the response this cycle.
REQ-008 SHALL have port STALL  output  1  hold upstream pipeline registers.
REQ-009 SHALL have port RSP_VALID  output  1  RSP_DATA/RSP_ERROR valid.
REQ-010 SHALL have port RSP_DATA  output  48  read data returned to writeback.
REQ-011 SHALL have port RSP_ERROR  output  1  access aborted by timeout.
REQ-012 SHALL have port MA_ENABLE  output  1  enable to the downstream memory access controller.
REQ-013 SHALL have port MA_CTRL  output  3  registered copy of REQ_CTRL.
REQ-014 SHALL have port MA_ADDRESS  output  48  registered copy of REQ_ADDRESS.
REQ-015 SHALL have port MA_READ  input  48  read data from the memory access controller.
REQ-016 SHALL have port MA_HANDSHAKE  input  1  memory access controller completion.
REQ-017 SHALL have port REQ_COUNT  output  16  completed-access counter (successful and timed out).

Function
REQ-018 SHALL implement states IDLE, WAIT, RESP, RELEASE in a registered state machine.
REQ-019 IDLE: when REQ_VALID=1, SHALL capture REQ_CTRL/REQ_ADDRESS into MA_CTRL/MA_ADDRESS, clear timeout counter, and go to WAIT next cycle; otherwise SHALL stay in IDLE.
REQ-020 MA_ENABLE SHALL equal 1 exactly while state is WAIT; MA_CTRL/MA_ADDRESS SHALL hold stable throughout WAIT.
REQ-021 WAIT: when MA_HANDSHAKE=1, SHALL register MA_READ into RSP_DATA, set RSP_ERROR=0, and go to RESP.
REQ-022 WAIT: each cycle without MA_HANDSHAKE SHALL increment the timeout counter; when it equals TIMEOUT_CYCLES-1, SHALL set RSP_DATA=0, RSP_ERROR=1, and go to RESP.
REQ-023 Handshake and timeout in the same cycle: handshake SHALL win (RSP_ERROR=0).
REQ-024 RSP_VALID SHALL equal 1 exactly while state is RESP; RSP_DATA/RSP_ERROR SHALL hold stable in RESP.
REQ-025 RESP: when WB_READY=1, SHALL increment REQ_COUNT (saturating at 16'hFFFF) and go to RELEASE; else stay in RESP.
REQ-026 RELEASE: MA_ENABLE SHALL be 0 for exactly one cycle, letting the downstream controller return to its idle state; then SHALL go to IDLE.
REQ-027 STALL SHALL be combinational: 1 when REQ_VALID=1 and not (state=RESP and WB_READY=1); 0 otherwise.
REQ-028 REQ_VALID deasserting during WAIT or RESP SHALL NOT abort the access; the transaction SHALL complete normally.
REQ-029 A REQ_VALID held high after RELEASE SHALL start a new access from IDLE; back-to-back accesses SHALL be separated by at least one MA_ENABLE=0 cycle.
REQ-030 Minimum latency: REQ_VALID in IDLE at cycle 0, MA_HANDSHAKE at cycle 1 -> RSP_VALID at cycle 2.

Reset
REQ-031 RESET=1 SHALL asynchronously force state IDLE, MA_ENABLE=0, MA_CTRL=0, MA_ADDRESS=0, RSP_VALID=0, RSP_DATA=0, RSP_ERROR=0, REQ_COUNT=0, and timeout counter 0.
REQ-032 RESET during WAIT SHALL drop MA_ENABLE immediately; a MA_HANDSHAKE arriving after reset SHALL be ignored in IDLE.

Verification
REQ-033 Single read: REQ_VALID=1, CTRL=3'b000, ADDRESS=48'h10; MA_HANDSHAKE after 5 cycles with MA_READ=48'hABCD, WB_READY=1 -> MA_ENABLE high 5 cycles, RSP_DATA=48'hABCD, RSP_ERROR=0, STALL low in RESP cycle, REQ_COUNT=1.
REQ-034 Timeout: TIMEOUT_CYCLES=8, no handshake -> RESP after 8 WAIT cycles, RSP_ERROR=1, RSP_DATA=0.
REQ-035 Backpressure: WB_READY=0 for 4 cycles in RESP -> RSP_VALID, RSP_DATA, and STALL=1 held; advances on the first WB_READY=1.
REQ-036 Back-to-back: two requests (CTRL bit0=0 then 1) -> one MA_ENABLE=0 RELEASE cycle between them; MA_CTRL=3'b001 on the second; REQ_COUNT=2.
REQ-037 Reset mid-WAIT: assert RESET asynchronously -> MA_ENABLE=0 before the next edge; all outputs at reset values; a later MA_HANDSHAKE does not set RSP_VALID.
REQ-038 Simultaneous: handshake on cycle TIMEOUT_CYCLES-1 -> RSP_ERROR=0 and RSP_DATA=MA_READ.
